// File: rtl/receptor_display.sv
// Serial display link receiver: synchronises io_* lines, deserialises MSB-first bytes
// into command / frame-buffer writes. Define RX_CMD_DECODE_EN to enable command decode.
module receptor_display #(
  parameter int FRAME_BYTES = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_sclk,
  input  logic              io_sdin,
  input  logic              io_cs,
  input  logic              io_dc,
  input  logic              io_reset,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              display_on,
  output logic [7:0]        abort_cnt
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_HOLDRST = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  logic [1:0]        sclk_sync_q, cs_sync_q, rst_sync_q, sdin_sync_q, dc_sync_q;
  logic              sclk_d_q, edge_q, sdin_q, dc_q;
  logic [1:0]        state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              cmd_valid_q, cmd_valid_d, wr_en_q, wr_en_d, frame_done_q, frame_done_d;
  logic [7:0]        cmd_byte_q, cmd_byte_d, wr_data_q, wr_data_d, abort_q, abort_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              disp_q, disp_d;
`ifndef RX_CMD_DECODE_EN
  logic              init_q;
`endif

  // Synchronisers and edge-detect stage; sclk chain idles high so a release never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b11;
      sclk_d_q    <= 1'b1;
      cs_sync_q   <= 2'b11;
      rst_sync_q  <= 2'b11;
      edge_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], io_sclk};
      sclk_d_q    <= sclk_sync_q[1];
      cs_sync_q   <= {cs_sync_q[0], io_cs};
      rst_sync_q  <= {rst_sync_q[0], io_reset};
      edge_q      <= sclk_sync_q[1] & ~sclk_d_q;
    end
  end

  // Data path: sdin/dc follow the same stage count as the sclk edge
  always_ff @(posedge clk) begin
    sdin_sync_q <= {sdin_sync_q[0], io_sdin};
    dc_sync_q   <= {dc_sync_q[0], io_dc};
    sdin_q      <= sdin_sync_q[1];
    dc_q        <= dc_sync_q[1];
    shift_q     <= shift_d;
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    cmd_valid_d  = 1'b0;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    wr_data_d    = wr_data_q;
    abort_d      = abort_q;
    disp_d       = disp_q;
    addr_d       = addr_q;
    // Address advances the cycle after the write pulse so wr_addr shows the written slot
    if (wr_en_q) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
`ifdef RX_CMD_DECODE_EN
    if (cmd_valid_q) begin
      if (cmd_byte_q == 8'hAF) disp_d = 1'b1;
      if (cmd_byte_q == 8'hAE) disp_d = 1'b0;
      if (cmd_byte_q == 8'h21 || cmd_byte_q == 8'h22) addr_d = '0;
    end
`else
    if (!init_q) disp_d = 1'b1;
`endif
    if (!rst_sync_q[1]) begin
      state_d  = ST_HOLDRST;
      bitcnt_d = '0;
      addr_d   = '0;
      disp_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bitcnt_d = '0;
          if (!cs_sync_q[1]) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (edge_q) begin
            shift_d  = {shift_q[6:0], sdin_q};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (dc_q) begin
                wr_en_d      = 1'b1;
                wr_data_d    = shift_d;
                frame_done_d = (addr_q == LAST_ADDR);
              end else begin
                cmd_valid_d = 1'b1;
                cmd_byte_d  = shift_d;
              end
            end
          end
          // A byte completing in the same cycle as cs rise is still delivered
          if (cs_sync_q[1]) begin
            state_d = ST_IDLE;
            if (bitcnt_d != 3'd0 && abort_q != 8'hFF) abort_d = abort_q + 8'd1;
            bitcnt_d = '0;
          end
        end
        ST_HOLDRST: begin
          bitcnt_d = '0;
          addr_d   = '0;
          disp_d   = 1'b0;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      cmd_valid_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_byte_q   <= '0;
      wr_data_q    <= '0;
      abort_q      <= '0;
      addr_q       <= '0;
      disp_q       <= 1'b0;
`ifndef RX_CMD_DECODE_EN
      init_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      cmd_valid_q  <= cmd_valid_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      cmd_byte_q   <= cmd_byte_d;
      wr_data_q    <= wr_data_d;
      abort_q      <= abort_d;
      addr_q       <= addr_d;
      disp_q       <= disp_d;
`ifndef RX_CMD_DECODE_EN
      init_q       <= 1'b1;
`endif
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_byte   = cmd_byte_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign display_on = disp_q;
  assign abort_cnt  = abort_q;
endmodule

// File: tb/tb_receptor_display.sv
// Bench for receptor_display: directed serial traffic, transaction-level expectation queue
// checked on every output pulse, plus literal spot checks.
module tb_receptor_display;
  localparam int FB = 1024;

  logic       clk = 1'b0;
  logic       rst_n, io_sclk, io_sdin, io_cs, io_dc, io_reset;
  logic       cmd_valid, wr_en, frame_done, display_on;
  logic [7:0] cmd_byte, wr_data, abort_cnt;
  logic [9:0] wr_addr;

  receptor_display #(.FRAME_BYTES(FB), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs),
    .io_dc(io_dc), .io_reset(io_reset), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .display_on(display_on), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_data;
    int data;
    int addr;
    bit fd;
    int due;
  } exp_t;

  exp_t expq[$];
  int   total = 0, bad = 0, cyc = 0;
  int   model_addr = 0, model_abort = 0, model_disp = 0;
  int   n_wr = 0, n_fd = 0, last_wr_addr = -1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every output pulse is matched against the next expected transaction
  always @(posedge clk) begin
    cyc++;
    #1;
    if (cmd_valid || wr_en) begin
      if (expq.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("pulse_both", int'(cmd_valid & wr_en), 0);
        chk("pulse_kind", int'(wr_en), int'(e.is_data));
        chk("pulse_cycle", cyc, e.due);
        if (e.is_data) begin
          chk("wr_data", int'(wr_data), e.data);
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("frame_done", int'(frame_done), int'(e.fd));
        end else begin
          chk("cmd_byte", int'(cmd_byte), e.data);
        end
      end
      if (wr_en) begin
        n_wr++;
        last_wr_addr = int'(wr_addr);
      end
      if (frame_done) n_fd++;
    end else begin
      if (frame_done) chk("stray_frame_done", 1, 0);
      if (expq.size() != 0 && expq[0].due < cyc) begin
        chk("missing_pulse", 0, 1);
        void'(expq.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] b, input logic dc);
    exp_t e;
    e.is_data = dc;
    e.data    = int'(b);
    e.addr    = model_addr;
    e.fd      = (model_addr == FB - 1);
    e.due     = cyc + 4;
    expq.push_back(e);
    if (dc) begin
      model_addr = (model_addr + 1) % FB;
    end else begin
`ifdef RX_CMD_DECODE_EN
      if (b == 8'h21 || b == 8'h22) model_addr = 0;
      if (b == 8'hAF) model_disp = 1;
      if (b == 8'hAE) model_disp = 0;
`endif
    end
  endtask

  // nbits < 8 leaves a partial byte; the 8th rising edge registers the expectation
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc, input int h);
    for (int i = 7; i > 7 - nbits; i--) begin
      io_sdin = b[i];
      io_dc   = dc;
      io_sclk = 1'b0;
      tick(h);
      io_sclk = 1'b1;
      if (i == 0) push_exp(b, dc);
      tick(h);
    end
  endtask

  task automatic start_xfer();
    io_cs = 1'b0;
    tick(4);
  endtask

  task automatic end_xfer(input int h);
    io_sclk = 1'b0;
    tick(h);
    io_cs = 1'b1;
    tick(6);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && expq.size() != 0; i++) tick(1);
    chk("drain_timeout", expq.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_display_on"}, int'(display_on), model_disp);
    chk({tag, "_abort_cnt"}, int'(abort_cnt), model_abort);
    chk({tag, "_wr_addr"}, int'(wr_addr), model_addr);
  endtask

  task automatic pulse_io_reset(input int n);
    io_reset   = 1'b0;
    model_addr = 0;
    model_disp = 0;
    tick(n);
    io_reset = 1'b1;
    tick(5);
  endtask

  initial begin
    int wr0, fd0;
    rst_n = 1'b0; io_sclk = 1'b0; io_sdin = 1'b0; io_cs = 1'b1; io_dc = 1'b0; io_reset = 1'b1;
    tick(3);
    chk("rst_outputs", int'({cmd_valid, wr_en, frame_done, display_on}), 0);
    chk("rst_values", int'({cmd_byte, wr_data, abort_cnt}), 0);
    chk("rst_addr", int'(wr_addr), 0);
    rst_n = 1'b1;
`ifndef RX_CMD_DECODE_EN
    model_disp = 1;
`endif
    tick(3);
    check_quiet("post_rst");

    // Command 0xAF, 8 clk per sclk period
    start_xfer();
    send_bits(8'hAF, 8, 1'b0, 4);
    end_xfer(4);
    drain();
    chk("af_cmd_byte", int'(cmd_byte), 8'hAF);
    chk("af_display_on", int'(display_on), 1);
    chk("af_no_write", n_wr, 0);
    check_quiet("af");

    // Full frame plus one byte under one cs low
    wr0 = n_wr; fd0 = n_fd;
    start_xfer();
    for (int k = 0; k <= FB; k++) send_bits(8'(k), 8, 1'b1, 3);
    end_xfer(3);
    drain();
    chk("frame_wr_count", n_wr - wr0, FB + 1);
    chk("frame_fd_count", n_fd - fd0, 1);
    chk("frame_wrap_addr", last_wr_addr, 0);
    chk("frame_last_data", int'(wr_data), 8'h00);
    check_quiet("frame");

    // Partial byte aborted, then a clean byte
    start_xfer();
    send_bits(8'hF0, 5, 1'b1, 3);
    io_sclk = 1'b0;
    tick(3);
    io_cs = 1'b1;
    model_abort++;
    tick(8);
    chk("abort_literal", int'(abort_cnt), 1);
    start_xfer();
    send_bits(8'h3C, 8, 1'b1, 3);
    end_xfer(3);
    drain();
    chk("after_abort_data", int'(wr_data), 8'h3C);
    check_quiet("abort");

    // Ten bytes, io_reset low 20 clk, one byte
    start_xfer();
    for (int k = 0; k < 10; k++) send_bits(8'(8'h40 + k), 8, 1'b1, 3);
    end_xfer(3);
    drain();
    pulse_io_reset(20);
    chk("holdrst_display_off", int'(display_on), 0);
    start_xfer();
    send_bits(8'h99, 8, 1'b1, 3);
    end_xfer(3);
    drain();
    chk("holdrst_byte_addr", last_wr_addr, 0);
    chk("holdrst_next_addr", int'(wr_addr), 1);
    check_quiet("holdrst");

    // Three data bytes, command 0x21, one data byte
    pulse_io_reset(10);
    start_xfer();
    send_bits(8'h11, 8, 1'b1, 3);
    send_bits(8'h22, 8, 1'b1, 3);
    send_bits(8'h33, 8, 1'b1, 3);
    send_bits(8'h21, 8, 1'b0, 3);
    send_bits(8'h44, 8, 1'b1, 3);
    end_xfer(3);
    drain();
`ifdef RX_CMD_DECODE_EN
    chk("cmd21_last_addr", last_wr_addr, 0);
`else
    chk("cmd21_last_addr", last_wr_addr, 3);
`endif
    check_quiet("cmd21");

    // rst_n in the middle of byte 2
    start_xfer();
    send_bits(8'h55, 8, 1'b1, 3);
    send_bits(8'hAA, 4, 1'b1, 3);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pulses", int'({cmd_valid, wr_en, frame_done, display_on}), 0);
    chk("async_rst_vals", int'({cmd_byte, wr_data, abort_cnt}), 0);
    chk("async_rst_addr", int'(wr_addr), 0);
    model_addr = 0; model_abort = 0; model_disp = 0;
    io_sclk = 1'b0;
    io_cs   = 1'b1;
    tick(3);
    rst_n = 1'b1;
`ifndef RX_CMD_DECODE_EN
    model_disp = 1;
`endif
    tick(12);
    chk("post_rst_no_pulse", expq.size(), 0);
    chk("post_rst_vals", int'({cmd_byte, wr_data}), 0);
    check_quiet("post_async");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
